// File: rtl/chess_pkg.sv
// Shared chess definitions for the knight-move path.
// Holds the board/piece widths, knight direction codes with their
// file/rank delta tables, piece and colour constants, and the
// sequencer state type.
package chess_pkg;

    localparam int unsigned SQ_W    = 6;
    localparam int unsigned PIECE_W = 4;
    localparam int unsigned NDIR    = 8;
    localparam int unsigned DIR_W   = $clog2(NDIR);
    localparam int unsigned NSQ     = 1 << SQ_W;
    localparam int unsigned COUNT_W = $clog2(NDIR + 1);
    localparam int unsigned DELTA_W = 4;

    localparam logic [PIECE_W-1:0] PIECE_EMPTY = '0;
    localparam logic               WHITE       = 1'b0;
    localparam logic               BLACK       = 1'b1;

    // Compass names: file increases eastward, rank increases northward.
    localparam logic [DIR_W-1:0] DIR_WSW = 3'd0;  // (-2,-1)
    localparam logic [DIR_W-1:0] DIR_SSW = 3'd1;  // (-1,-2)
    localparam logic [DIR_W-1:0] DIR_SSE = 3'd2;  // (+1,-2)
    localparam logic [DIR_W-1:0] DIR_ESE = 3'd3;  // (+2,-1)
    localparam logic [DIR_W-1:0] DIR_ENE = 3'd4;  // (+2,+1)
    localparam logic [DIR_W-1:0] DIR_NNE = 3'd5;  // (+1,+2)
    localparam logic [DIR_W-1:0] DIR_NNW = 3'd6;  // (-1,+2)
    localparam logic [DIR_W-1:0] DIR_WNW = 3'd7;  // (-2,+1)

    // Signed 4-bit deltas packed with direction 0 in the low nibble.
    localparam logic [NDIR*DELTA_W-1:0] DFILE_TBL = 32'hEF12_21FE;
    localparam logic [NDIR*DELTA_W-1:0] DRANK_TBL = 32'h1221_FEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Table lookups; {dir, 2'b00} is dir*DELTA_W without overflowing dir's width.
    function automatic logic signed [DELTA_W-1:0] knight_dfile(input logic [DIR_W-1:0] dir);
        return $signed(DFILE_TBL[{dir, 2'b00} +: DELTA_W]);
    endfunction

    function automatic logic signed [DELTA_W-1:0] knight_drank(input logic [DIR_W-1:0] dir);
        return $signed(DRANK_TBL[{dir, 2'b00} +: DELTA_W]);
    endfunction

endpackage

// File: rtl/knight_onboard_check.sv
// Combinational check that a knight jump from origin in direction dir
// lands on the board.
// Ports:
//   origin   in  square index (rank*8 + file)
//   dir      in  knight direction code
//   on_board out 1 when the destination file and rank are both 0..7
module knight_onboard_check
    import chess_pkg::*;
(
    input  logic [SQ_W-1:0]  origin,
    input  logic [DIR_W-1:0] dir,
    output logic             on_board
);

    logic signed [DELTA_W-1:0] file_n;
    logic signed [DELTA_W-1:0] rank_n;

    // Sums span -2..9; in 4-bit two's complement exactly 0..7 has bit 3 clear,
    // so 8 and 9 (1000, 1001) and negatives are all rejected without wrap.
    always_comb begin
        file_n   = $signed({1'b0, origin[2:0]}) + knight_dfile(dir);
        rank_n   = $signed({1'b0, origin[5:3]}) + knight_drank(dir);
        on_board = !file_n[DELTA_W-1] && !rank_n[DELTA_W-1];
    end

endmodule

// File: rtl/knight_scan_sequencer.sv
// Drives the shared knight-move scanner through all eight directions for
// one origin square, filters off-board and own-colour destinations, and
// reports a legal-destination mask and move count.
// Optional macro KNIGHT_CAPTURE_MASK_EN builds capture_mask (legal
// destinations holding an opponent piece); otherwise it is tied to 0.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, origin, side scan request; origin/side latched on accept in IDLE
//   scan_pos, scan_dir  position/direction presented to the scanner
//   scan_dst, scan_piece scanner result, one cycle after issue
//   busy, done          busy while not IDLE; done pulses with final results
//   move_mask, move_count, capture_mask  results, held until next accept
module knight_scan_sequencer
    import chess_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SQ_W-1:0]     origin,
    input  logic                side,
    output logic [SQ_W-1:0]     scan_pos,
    output logic [DIR_W-1:0]    scan_dir,
    input  logic [SQ_W-1:0]     scan_dst,
    input  logic [PIECE_W-1:0]  scan_piece,
    output logic                busy,
    output logic                done,
    output logic [NSQ-1:0]      move_mask,
    output logic [COUNT_W-1:0]  move_count,
    output logic [NSQ-1:0]      capture_mask
);

    state_t             state;
    state_t             state_next;
    logic               busy_next;
    logic               done_next;
    logic               accept;
    logic               side_q;
    logic [DIR_W-1:0]   dir_q;
    logic               valid_q;
    logic               on_board;
    logic               legal;

    // On-board test uses the latched origin, never the scanner's output.
    knight_onboard_check u_onboard (
        .origin   (scan_pos),
        .dir      (dir_q),
        .on_board (on_board)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_dir == DIR_W'(NDIR - 1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    // Result of the direction issued last cycle is judged this cycle.
    always_comb begin
        legal = valid_q && on_board &&
                ((scan_piece == PIECE_EMPTY) || (scan_piece[PIECE_W-1] != side_q));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control outputs, issue pipeline and result accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            scan_pos   <= '0;
            scan_dir   <= '0;
            side_q     <= 1'b0;
            dir_q      <= '0;
            valid_q    <= 1'b0;
            move_mask  <= '0;
            move_count <= '0;
        end else begin
            busy    <= busy_next;
            done    <= done_next;
            dir_q   <= scan_dir;
            valid_q <= (state == ST_SCAN);
            if (accept) begin
                scan_pos   <= origin;
                side_q     <= side;
                scan_dir   <= '0;
                move_mask  <= '0;
                move_count <= '0;
            end else begin
                if (state == ST_SCAN) begin
                    scan_dir <= scan_dir + DIR_W'(1);
                end
                if (legal) begin
                    move_mask[scan_dst] <= 1'b1;
                    move_count          <= move_count + COUNT_W'(1);
                end
            end
        end
    end

`ifdef KNIGHT_CAPTURE_MASK_EN
    // Legal destinations occupied by an opponent piece.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture_mask <= '0;
        end else if (accept) begin
            capture_mask <= '0;
        end else if (legal && (scan_piece != PIECE_EMPTY)) begin
            capture_mask[scan_dst] <= 1'b1;
        end
    end
`else
    assign capture_mask = '0;
`endif

endmodule
